sipo_deframer: RTL
==================

Name: sipo_deframer

Overview:
Serial-to-parallel receive stage that sits directly downstream of the 4-bit PISO shift register. It consumes the Serial_Out bit stream and reassembles MSB-first words of WIDTH bits. Completed words go to a one-entry output holding register with a valid/ready handshake, plus sticky overrun and framing-error flags and a delivered-word counter.

Parameters:
WIDTH, 4, bits per word; must be 2 or more.
CNT_W, 8, width of the delivered-word counter.

Ports:
Clk  input  1  single clock; all state changes on the rising edge.
Rst_n  input  1  asynchronous active-low reset.
Serial_In  input  1  serial data bit, MSB of the word first.
Serial_Valid  input  1  Serial_In is sampled on this edge only when high.
Frame_Start  input  1  qualified by Serial_Valid; marks the current bit as bit 0 (MSB) of a new word.
Out_Ready  input  1  consumer accepts Parallel_Out when Out_Valid and Out_Ready are both high.
Clear_Err  input  1  clears Overrun and Frame_Err.
Parallel_Out  output  WIDTH  assembled word; first received bit at [WIDTH-1].
Out_Valid  output  1  Parallel_Out holds an unconsumed word.
Overrun  output  1  sticky; a completed word was dropped.
Frame_Err  output  1  sticky; Frame_Start arrived while a partial word was in progress.
Bit_Count  output  $clog2(WIDTH)  number of bits of the partial word collected so far.
Word_Count  output  CNT_W  words delivered into the holding register; wraps modulo 2^CNT_W.

Behaviour:
- Reset (Rst_n low, asynchronous): shift register, Parallel_Out, Bit_Count and Word_Count go to 0; Out_Valid, Overrun and Frame_Err go to 0. Reset mid-word discards the partial word and any held word.
- Shift: on each edge with Serial_Valid=1, shreg <= {shreg[WIDTH-2:0], Serial_In}. Bit_Count increments.
- Frame_Start with Serial_Valid=1 and Bit_Count≠0:
  - Partial bits are discarded and Frame_Err is set.
  - Current bit becomes bit 0 and Bit_Count becomes 1.
  - With Bit_Count=0, Frame_Start is legal and has no side effect.
- Frame_Start with Serial_Valid=0 is ignored.
- Word completion happens on an edge where Serial_Valid=1 and Bit_Count=WIDTH-1 (with no restarting Frame_Start):
  - Bit_Count wraps to 0.
  - The full word {shreg[WIDTH-2:0], Serial_In} is the completed word.
- Holding register, with slot_free = !Out_Valid || Out_Ready:
  - Completion and slot_free: Parallel_Out <= word, Out_Valid <= 1, Word_Count += 1.
  - Completion and not slot_free: word dropped, Parallel_Out unchanged, Out_Valid stays 1, Overrun <= 1, Word_Count unchanged.
  - No completion and Out_Valid && Out_Ready: Out_Valid <= 0; Parallel_Out holds its last value.
- Latency: Out_Valid rises on the same edge that samples the last bit, so it is visible in the cycle after the WIDTH-th valid bit.
- Throughput: back-to-back words with Out_Ready tied high are lossless.
- Clear_Err: clears Overrun and Frame_Err on the next edge. If an error event occurs on the same edge, set wins.
- Parallel_Out is stable while Out_Valid=1 and Out_Ready=0.
- Serial_Valid gaps of any length between bits are allowed; the partial state is held.
- Word_Count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset, then bits 1,0,1,0 with Serial_Valid=1, Frame_Start on the first bit, Out_Ready=1 -> Parallel_Out=4'b1010, Out_Valid high for 1 cycle, Word_Count=1.
- Continuous stream of words 1100, 1111, 0101 with no idle cycles, Out_Ready=1 -> three Out_Valid pulses spaced 4 cycles apart, outputs 1100/1111/0101, Overrun=0.
- Out_Ready=0, send 1010 then 0110 -> Parallel_Out stays 1010, Overrun=1, Word_Count=1. Then Out_Ready=1 for 1 cycle -> Out_Valid=0. Then Clear_Err -> Overrun=0.
- Out_Valid=1 holding 1010 while a new word 0011 completes on the same edge Out_Ready=1 -> Parallel_Out=0011, Out_Valid stays 1, no Overrun, Word_Count=2.
- Send 2 bits, then Frame_Start with bits 1,1,0,0 -> Frame_Err=1, Parallel_Out=1100. Also: Rst_n low mid-word (Bit_Count=2) -> all outputs 0 immediately, and the next word decodes correctly.
- Bits separated by random Serial_Valid gaps of 0-5 cycles, 20 random words -> all words match in order; with CNT_W=2, Word_Count reads 0 after 4 words.

Source files
------------

// File: rtl/sipo_deframer.sv
// sipo_deframer: serial-to-parallel receive stage for an MSB-first bit stream.
// Collects WIDTH-bit words, hands them to a one-entry holding register with a
// valid/ready handshake, and keeps sticky overrun / framing-error flags plus a
// count of words delivered into the holding register.
module sipo_deframer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Serial_In,
  input  logic                     Serial_Valid,
  input  logic                     Frame_Start,
  input  logic                     Out_Ready,
  input  logic                     Clear_Err,
  output logic [WIDTH-1:0]         Parallel_Out,
  output logic                     Out_Valid,
  output logic                     Overrun,
  output logic                     Frame_Err,
  output logic [$clog2(WIDTH)-1:0] Bit_Count,
  output logic [CNT_W-1:0]         Word_Count
);

  localparam int BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             restart;
  logic             complete;
  logic             slot_free;
  logic [WIDTH-1:0] word_full;

  // Qualify the incoming bit: restart of a partial word, or completion of a word.
  always_comb begin
    restart   = Serial_Valid && Frame_Start && (bit_cnt_q != '0);
    complete  = Serial_Valid && !restart && (bit_cnt_q == LAST_BIT);
    slot_free = !valid_q || Out_Ready;
    word_full = {shreg_q[WIDTH-2:0], Serial_In};
  end

  // Shift register and bit counter; a restart drops the partial bits so only
  // the current bit survives as the new MSB.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (Serial_Valid) begin
      if (restart) begin
        shreg_d   = {{(WIDTH-1){1'b0}}, Serial_In};
        bit_cnt_d = BC_W'(1);
      end else if (complete) begin
        shreg_d   = word_full;
        bit_cnt_d = '0;
      end else begin
        shreg_d   = word_full;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
      end
    end
  end

  // Holding register: load when the slot is free (a consumer pop on the same
  // edge frees it), otherwise drop the new word and flag the overrun.
  always_comb begin
    hold_d     = hold_q;
    valid_d    = valid_q;
    word_cnt_d = word_cnt_q;
    if (complete && slot_free) begin
      hold_d     = word_full;
      valid_d    = 1'b1;
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end else if (!complete && valid_q && Out_Ready) begin
      valid_d = 1'b0;
    end
  end

  // Sticky error flags; a new error event on the clearing edge takes priority.
  always_comb begin
    ovr_d  = Clear_Err ? 1'b0 : ovr_q;
    ferr_d = Clear_Err ? 1'b0 : ferr_q;
    if (complete && !slot_free) begin
      ovr_d = 1'b1;
    end
    if (restart) begin
      ferr_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign Parallel_Out = hold_q;
  assign Out_Valid    = valid_q;
  assign Overrun      = ovr_q;
  assign Frame_Err    = ferr_q;
  assign Bit_Count    = bit_cnt_q;
  assign Word_Count   = word_cnt_q;

endmodule
